// File: rtl/ets_window_accumulator.sv
// ETS window accumulator: trigger-delayed window capture, per-bin averaging,
// and a valid/ready dump of bin counts to the sample buffer.
module ets_window_accumulator #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              shifting_clk,
  input  logic              S_AXI_DATA_aresetn,
  input  logic              en,
  input  logic              cmp_data,
  input  logic              trigger,
  input  logic [15:0]       delay,
  input  logic [15:0]       average,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       trig_count,
  output logic [7:0]        overrun_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_DELAY,
    S_CAPTURE,
    S_DUMP,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic              en_m_q, en_s_q;
  logic [1:0]        prime_q;
  logic              low_seen_q;
  logic [ADDR_W-1:0] idx_q;
  logic [15:0]       dly_q;
  logic [15:0]       avg_q;
  logic [15:0]       trig_q;
  logic [7:0]        ovr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  acc_q [DEPTH];

  logic              rise;
  logic              last;
  logic              take;
  logic              fin;
  logic              ign;
  logic [ADDR_W-1:0] idx_inc;
  logic [15:0]       trig_inc;
  logic [CNT_W:0]    sum_d;
  logic [CNT_W-1:0]  acc_d;

  // A rise only counts once en_s has been seen low after reset.
  assign rise     = en_s_q & low_seen_q;
  assign last     = idx_q == LAST;
  assign take     = valid_q & out_ready;
  assign idx_inc  = idx_q + ADDR_W'(1);
  assign trig_inc = trig_q + 16'd1;
  assign fin      = trig_inc == avg_q;
  assign ign      = en_s_q & trigger &
                    (state_q inside {S_CLEAR, S_DELAY, S_CAPTURE,
                                     S_DUMP, S_DONE});
  assign sum_d    = {1'b0, acc_q[idx_q]} + (CNT_W + 1)'(cmp_data);
  assign acc_d    = sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    if (!en_s_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (rise) state_d = S_CLEAR;
        S_CLEAR:   if (last) state_d = S_ARM;
        S_ARM:     if (trigger)
                     state_d = (delay == 16'd0) ? S_CAPTURE : S_DELAY;
        S_DELAY:   if (dly_q == 16'd1) state_d = S_CAPTURE;
        S_CAPTURE: if (last) state_d = fin ? S_DUMP : S_ARM;
        S_DUMP:    if (take && last) state_d = S_DONE;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge shifting_clk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      state_q    <= S_IDLE;
      en_m_q     <= 1'b0;
      en_s_q     <= 1'b0;
      prime_q    <= '0;
      low_seen_q <= 1'b0;
      idx_q      <= '0;
      dly_q      <= '0;
      avg_q      <= '0;
      trig_q     <= '0;
      ovr_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_m_q  <= en;
      en_s_q  <= en_m_q;
      prime_q <= {prime_q[0], 1'b1};
      if (rise)
        low_seen_q <= 1'b0;
      else if (prime_q[1] && !en_s_q)
        low_seen_q <= 1'b1;
      state_q <= state_d;
      busy_q  <= !(state_d inside {S_IDLE, S_DONE});
      done_q  <= state_d == S_DONE;
      if (ign && ovr_q != 8'hFF)
        ovr_q <= ovr_q + 8'd1;
      if (!en_s_q) begin
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (rise) begin
            avg_q  <= (average == 16'd0) ? 16'd1 : average;
            trig_q <= '0;
            ovr_q  <= '0;
            idx_q  <= '0;
          end
          S_CLEAR: idx_q <= idx_inc;
          S_ARM: begin
            idx_q <= '0;
            if (trigger) dly_q <= delay;
          end
          S_DELAY: dly_q <= dly_q - 16'd1;
          S_CAPTURE: begin
            idx_q <= idx_inc;
            if (last) begin
              trig_q <= trig_inc;
              if (fin) begin
                valid_q <= 1'b1;
                addr_q  <= '0;
                data_q  <= 32'(acc_q[0]);
              end
            end
          end
          S_DUMP: if (take) begin
            if (last) begin
              valid_q <= 1'b0;
            end else begin
              idx_q  <= idx_inc;
              addr_q <= idx_inc;
              data_q <= 32'(acc_q[idx_inc]);
            end
          end
          S_DONE: ;
          default: ;
        endcase
      end
    end
  end

  // Bins survive reset; the CLEAR pass zeroes them at the start of a run.
  always_ff @(posedge shifting_clk) begin
    if (en_s_q && state_q == S_CLEAR)
      acc_q[idx_q] <= '0;
    else if (en_s_q && state_q == S_CAPTURE)
      acc_q[idx_q] <= acc_d;
  end

  assign out_valid     = valid_q;
  assign out_addr      = addr_q;
  assign out_data      = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign trig_count    = trig_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_ets_window_accumulator.sv
// Directed bench for ets_window_accumulator: one default instance and one
// with 4-bit bins share stimulus so saturation shows up on the narrow one.
module tb_ets_window_accumulator;

  logic        clk = 1'b0;
  logic        rstn, en, cmp, trig, ready;
  logic [15:0] dly, avg;

  logic        v_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  logic [15:0] tc_a;
  logic [7:0]  ov_a;

  logic        v_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  logic [15:0] tc_b;
  logic [7:0]  ov_b;

  int nvec = 0;
  int nerr = 0;
  int exp_a [32];
  int exp_b [32];

  always #5 clk = ~clk;

  ets_window_accumulator dut (
    .shifting_clk(clk), .S_AXI_DATA_aresetn(rstn), .en(en),
    .cmp_data(cmp), .trigger(trig), .delay(dly), .average(avg),
    .out_valid(v_a), .out_ready(ready), .out_addr(addr_a),
    .out_data(data_a), .busy(busy_a), .done(done_a),
    .trig_count(tc_a), .overrun_count(ov_a)
  );

  ets_window_accumulator #(.CNT_W(4)) dut4 (
    .shifting_clk(clk), .S_AXI_DATA_aresetn(rstn), .en(en),
    .cmp_data(cmp), .trigger(trig), .delay(dly), .average(avg),
    .out_valid(v_b), .out_ready(ready), .out_addr(addr_b),
    .out_data(data_b), .busy(busy_b), .done(done_b),
    .trig_count(tc_b), .overrun_count(ov_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] a);
    en  = 1'b0;
    avg = a;
    repeat (4) tick();
    en = 1'b1;
    repeat (40) tick();
    chk("arm_busy", 32'(busy_a), 1);
    chk("arm_trig", 32'(tc_a), 0);
    chk("arm_ovr", 32'(ov_a), 0);
  endtask

  task automatic window(input int d, input logic [31:0] pat);
    dly  = 16'(d);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (d) tick();
    for (int k = 0; k < 32; k++) begin
      cmp = pat[k];
      tick();
    end
    cmp = 1'b0;
  endtask

  task automatic dump_check(input string tag, input bit toggle);
    int n = 0;
    int cyc = 0;
    logic [3:0] rp = 4'b1001;
    while (n < 32 && cyc < 200) begin
      ready = toggle ? rp[cyc % 4] : 1'b1;
      chk({tag, "_valid"}, 32'(v_a), 1);
      chk({tag, "_addr"}, 32'(addr_a), 32'(n));
      chk({tag, "_data"}, data_a, 32'(exp_a[n]));
      chk({tag, "_data4"}, data_b, 32'(exp_b[n]));
      if (ready) n++;
      tick();
      cyc++;
    end
    ready = 1'b0;
    chk({tag, "_count"}, 32'(n), 32);
    chk({tag, "_done"}, 32'(done_a), 1);
    chk({tag, "_done4"}, 32'(done_b), 1);
    chk({tag, "_vlow"}, 32'(v_a), 0);
    chk({tag, "_idle"}, 32'(busy_a), 0);
  endtask

  initial begin
    rstn  = 1'b0;
    en    = 1'b0;
    cmp   = 1'b0;
    trig  = 1'b0;
    ready = 1'b0;
    dly   = '0;
    avg   = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(v_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", data_a, 0);
    rstn = 1'b1;
    tick();

    // single trigger, 16 leading hits
    start_run(16'd1);
    for (int k = 0; k < 32; k++) begin
      exp_a[k] = (k < 16) ? 1 : 0;
      exp_b[k] = exp_a[k];
    end
    window(0, 32'h0000FFFF);
    chk("basic_trig", 32'(tc_a), 1);
    dump_check("basic", 1'b0);

    // triggers every 20 cycles: alternate ones land mid-capture
    start_run(16'd3);
    for (int c = 0; c <= 112; c++) begin
      trig = (c % 20 == 0) && (c <= 80);
      cmp  = 1'b1;
      tick();
    end
    trig = 1'b0;
    cmp  = 1'b0;
    chk("ovr_count", 32'(ov_a), 2);
    chk("ovr_trig", 32'(tc_a), 3);
    for (int k = 0; k < 32; k++) begin
      exp_a[k] = 3;
      exp_b[k] = 3;
    end
    dump_check("ovr", 1'b1);

    // async reset in the middle of a capture
    start_run(16'd4);
    window(0, 32'hFFFFFFFF);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("mid_ovr", 32'(ov_a), 1);
    chk("mid_trig", 32'(tc_a), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_trig", 32'(tc_a), 0);
    chk("arst_ovr", 32'(ov_a), 0);
    chk("arst_valid", 32'(v_a), 0);
    tick();
    rstn = 1'b1;
    repeat (50) tick();
    chk("norun_busy", 32'(busy_a), 0);
    chk("norun_done", 32'(done_a), 0);

    // delayed window, hit on bin 3 only
    start_run(16'd8);
    for (int w = 0; w < 8; w++) window(10, 32'h00000008);
    chk("dly_trig", 32'(tc_a), 8);
    chk("dly_ovr", 32'(ov_a), 0);
    for (int k = 0; k < 32; k++) begin
      exp_a[k] = (k == 3) ? 8 : 0;
      exp_b[k] = exp_a[k];
    end
    dump_check("delay", 1'b0);

    // 20 all-hit windows: narrow instance saturates at 15
    start_run(16'd20);
    for (int w = 0; w < 20; w++) window(0, 32'hFFFFFFFF);
    chk("sat_trig", 32'(tc_a), 20);
    for (int k = 0; k < 32; k++) begin
      exp_a[k] = 20;
      exp_b[k] = 15;
    end
    dump_check("sat", 1'b0);
    en = 1'b0;
    tick();
    tick();
    chk("done_hold", 32'(done_a), 1);
    tick();
    chk("done_clr", 32'(done_a), 0);
    chk("done_clr4", 32'(done_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ets_window_accumulator.md
Name: ets_window_accumulator

Overview:
- Upstream stage of the ETS capture system, in the shifting_clk domain.
- Consumes the registered comparator bit and the phase-aligned trigger pulse.
- After each trigger it waits a programmable delay, then samples a window of DEPTH comparator bits, and sums each bin over AVERAGE triggers.
- It then streams the per-bin hit counts to the downstream sample buffer through a valid/ready write port.

Parameters:
DEPTH, 32, bins per window (power of two, 4..256)
ADDR_W, 5, log2(DEPTH)
CNT_W, 16, accumulator width per bin (saturating)

Ports:
shifting_clk  in  1  sample clock (phase-shifted by MMCM)
S_AXI_DATA_aresetn  in  1  reset
en  in  1  run enable, quasi-static from register file; 2-FF synchronised internally
cmp_data  in  1  registered comparator bit
trigger  in  1  single-cycle trigger pulse, shifting_clk domain
delay  in  16  cycles from trigger to bin 0 (sampled at trigger)
average  in  16  triggers to accumulate (0 treated as 1; sampled on en rise)
out_valid  out  1  bin word valid
out_ready  in  1  downstream accepts
out_addr  out  ADDR_W  bin index
out_data  out  32  bin count, zero-extended
busy  out  1  high in any state except IDLE/DONE
done  out  1  high in DONE
trig_count  out  16  triggers accumulated this run
overrun_count  out  8  triggers ignored (saturating at 255)

Behaviour:
- Reset: S_AXI_DATA_aresetn, asynchronous, active-low; clock shifting_clk. All outputs 0, state IDLE, en synchroniser cleared. Bins are not cleared by reset (CLEAR does it).
- en_s = en after 2 FFs. The rise of en_s is detected, and all control below uses en_s.
- Abort rule: en_s low in any state puts the block in IDLE on the next cycle. out_valid drops with no handshake; downstream discards a partial dump.
- IDLE:
  - On en_s rise: latch avg_l = max(average,1); clear trig_count and overrun_count; bin index i=0; go to CLEAR.
- CLEAR:
  - Write acc[i]=0, one bin per cycle, i=0..DEPTH-1.
  - After bin DEPTH-1 go to ARM, so CLEAR takes exactly DEPTH cycles.
- ARM:
  - On trigger at cycle T: latch dly=delay.
  - If dly==0, go to CAPTURE; bin 0 is sampled at T+1.
  - Otherwise go to DELAY; bin 0 is sampled at T+1+dly.
- DELAY:
  - Count down dly; on reaching 1, go to CAPTURE.
- CAPTURE:
  - For k=0..DEPTH-1 on consecutive cycles: acc[k] = acc[k]+cmp_data, saturating at 2^CNT_W-1.
  - After bin DEPTH-1, trig_count increments.
  - If the new trig_count == avg_l, go to DUMP with i=0; otherwise go to ARM.
  - A trigger coincident with the last capture cycle is ignored, not queued.
- Triggers seen in DELAY, CAPTURE, CLEAR, DUMP or DONE are ignored and increment overrun_count (saturating). IDLE triggers are not counted.
- DUMP:
  - out_valid=1, out_addr=i, out_data={0,acc[i]}, registered.
  - Values are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, i increments. Acceptance of bin DEPTH-1 leads to DONE.
  - Throughput is 1 word/cycle when out_ready stays high.
- DONE:
  - done=1; hold bins and counters.
  - en_s low → IDLE, which clears done. Re-assert en for a new run.
- Widths: trig_count is compared against the 16-bit avg_l; delay up to 65535 cycles; out_addr wraps never (DUMP ends at DEPTH-1).
- Storage: bins may be distributed RAM or registers. Only one bin is read-modified-written per cycle, with no read hazard (consecutive addresses).

Test Plan:
- Reset mid-CAPTURE (DEPTH=32, avg=4) → all outputs 0 asynchronously. After release with en held high, no run starts until en toggles low→high.
- en rise, average=1, delay=0, cmp_data=1 for the 16 cycles after the trigger then 0, out_ready=1 → 32 words, addr 0..31, data=1 for addr 0..15 and 0 for 16..31; done=1; trig_count=1.
- average=8, delay=10, cmp_data high only on the 3rd cycle after each bin-0 cycle → dump shows acc[3]=8, all others 0. Bin 0 lands exactly 11 cycles after the trigger.
- Trigger every 20 cycles with DEPTH=32, delay=0, average=3 → every other trigger ignored; overrun_count=2 at dump; trig_count=3.
- out_ready toggling 1,0,0,1 during DUMP → out_addr/out_data hold while not ready; exactly 32 accepted words, no duplicates or skips.
- CNT_W=4, average=20, cmp_data=1 constant → all bins read 15 (saturated); en deasserted in DONE → IDLE, done=0 next cycle.
